mod5_sequence_monitor: RTL and testbench
========================================

Name: mod5_sequence_monitor

Overview:
Downstream consumer of the synchronous mod-5 counter's 3-bit state. Samples the count each enabled clock and checks that it follows the legal sequence 0→1→2→3→4→0. Once the sequence is proven, the block is locked: it then emits a pulse on each 4→0 wrap and accumulates those wraps. Flags illegal values and illegal transitions so that counter faults are visible at the system level.

Parameters:
WRAP_W, 8, width of the wrap accumulator WrapCount.
LOCK_CNT, 4, number of consecutive legal successor transitions required to enter LOCKED (range 1..7).

Ports:
Clock  input  1  rising-edge clock, same domain as the counter.
Reset  input  1  asynchronous, active-high reset.
Enable  input  1  sample qualifier; when low, Count is ignored.
Count  input  3  counter state, binary, MSB first.
Clear  input  1  synchronous clear of WrapCount, ErrorSticky and ErrCode.
WrapPulse  output  1  one-cycle pulse per wrap detected while LOCKED.
WrapCount  output  WRAP_W  number of wraps seen while LOCKED; saturates at all-ones.
Locked  output  1  high while the FSM is in LOCKED.
ErrorSticky  output  1  set on any detected error; held until Clear.
ErrCode  output  2  last error: 00 none, 01 illegal value (5/6/7), 10 bad transition.

Behaviour:
- Reset values:
  - Registers: FSM=SEARCH, prev=0, prev_valid=0, good_run=0.
  - Outputs: all outputs 0.
- Successor rule: next(v) = v+1 for v in 0..3; next(4) = 0.
- A legal sample is Count ≤ 4.
- Enable=0 (no sample):
  - state, prev, prev_valid, good_run and WrapCount all hold;
  - WrapPulse=0.
- Every enabled sample with a legal Count sets prev=Count and prev_valid=1.
- Every enabled sample with an illegal Count sets prev_valid=0.
- All outputs are registered; effects appear one cycle after the sampling edge.
- FSM states:
  - SEARCH:
    - Illegal Count: set ErrorSticky, ErrCode=01, good_run=0.
    - Legal Count with prev_valid and Count==next(prev): good_run++.
    - Any other legal Count: good_run=0.
    - When good_run reaches LOCK_CNT: go to LOCKED.
    - In SEARCH, wraps are neither pulsed nor counted.
  - LOCKED:
    - Count==next(prev): stay in LOCKED.
    - If additionally prev==4 and Count==0: WrapPulse=1 for one cycle; WrapCount++ (saturating).
    - Repeated value or any other non-successor (legal): go to FAULT, ErrCode=10, ErrorSticky=1.
    - Illegal value: go to FAULT, ErrCode=01, ErrorSticky=1.
  - FAULT:
    - Locked=0, good_run=0.
    - On the next enabled sample, return to SEARCH; that sample is evaluated as a SEARCH sample (prev/prev_valid rules apply).
- Locked = (state==LOCKED), registered.
- Clear priority and interactions:
  - Clear zeroes WrapCount, ErrorSticky and ErrCode.
  - An error detected in the same cycle wins: the sticky flag and code are set.
  - A wrap in the same cycle as Clear leaves WrapCount=1.
  - Clear does not change FSM state or good_run.
- Saturation: WrapCount stops at 2^WRAP_W−1; WrapPulse still fires on each wrap.
- Reset asserted mid-operation: immediate return to reset values, independent of Clock.
- First sample after reset has prev_valid=0, so it can never count as a transition.

Decomposition:
- Package mod5_mon_pkg contains:
  - state enum SEARCH/LOCKED/FAULT;
  - ErrCode constants ERR_NONE/ERR_ILLEGAL/ERR_TRANS;
  - constant MOD5_MAX=4;
  - pure function mod5_next(v).
- One natural sub-module: sat_counter (parameter W; inputs inc and clr; saturating at all-ones), instantiated for WrapCount.
- The FSM and checker stay in the top module.

Test Plan:
- Reset, Enable=1, Count=0,1,2,3,4,0,1 → Locked=1 the cycle after the sample of 4; WrapPulse=1 the cycle after the 0 sample; WrapCount=1; ErrorSticky=0.
- Locked, then Count=2,2 (repeat) → Locked=0 and ErrorSticky=1 next cycle; ErrCode=10; FSM passes through FAULT to SEARCH; WrapCount holds.
- In SEARCH, Count=6 → ErrorSticky=1, ErrCode=01, good_run reset. Then 0,1,2,3,4 → relock after 4 legal transitions.
- Locked, Enable toggled 1,0,1 over samples 3,(x),4 → no error; Enable=0 cycle changes nothing; WrapPulse only on a later enabled 4→0.
- WRAP_W=2, run 5 full wraps while locked → WrapCount=3 (saturated); five WrapPulses observed. Clear coinciding with the fifth wrap → WrapCount=1.
- Reset asserted asynchronously mid-cycle while LOCKED with WrapCount=2 → all outputs 0 immediately; relock requires LOCK_CNT fresh transitions.

Source files
------------

// File: rtl/mod5_mon_pkg.sv
// Shared definitions for the mod-5 sequence monitor: FSM state encoding,
// error codes and the mod-5 successor helper.
package mod5_mon_pkg;

   // Monitor FSM states, encoded explicitly so state values stay stable
   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      LOCKED = 2'd1,
      FAULT  = 2'd2
   } mon_state_e;

   // Error codes reported on ErrCode (last error seen)
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TRANS   = 2'b10;

   // Highest legal counter value
   localparam logic [2:0] MOD5_MAX = 3'd4;

   // Legal successor of a mod-5 value; anything at or above the maximum
   // folds back to zero so the function is total over 3 bits
   function automatic logic [2:0] mod5_next(input logic [2:0] v);
      logic [2:0] nextVal;
      if (v >= MOD5_MAX) begin
         nextVal = 3'd0;
      end else begin
         nextVal = v + 3'd1;
      end
      return nextVal;
   endfunction

endpackage

// File: rtl/mod5_sequence_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear and an increment
// in the same cycle leave the counter at one, so the event that coincides
// with the clear is not lost.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear wins over hold, increment stops at all-ones
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = inc_i ? W'(1) : '0;
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register with asynchronous reset
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mod5_sequence_monitor.sv
// Monitors the 3-bit state of a mod-5 counter. It searches for a run of
// legal successor transitions, locks once the run is long enough, then
// pulses and counts every 4->0 wrap. Illegal values and broken transitions
// are reported through a sticky flag and a last-error code.
module mod5_sequence_monitor
   import mod5_mon_pkg::*;
#(
   parameter int WRAP_W   = 8,
   parameter int LOCK_CNT = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Enable,
   input  logic [2:0]        Count,
   input  logic              Clear,
   output logic              WrapPulse,
   output logic [WRAP_W-1:0] WrapCount,
   output logic              Locked,
   output logic              ErrorSticky,
   output logic [1:0]        ErrCode
);

   localparam logic [2:0] LockTarget = 3'(LOCK_CNT);

   mon_state_e state_q;
   mon_state_e state_d;
   logic [2:0] prev_q;
   logic [2:0] prev_d;
   logic       prevValid_q;
   logic       prevValid_d;
   logic [2:0] goodRun_q;
   logic [2:0] goodRun_d;
   logic       wrapPulse_q;
   logic       errorSticky_q;
   logic [1:0] errCode_q;

   logic       legalSample;
   logic       isSuccessor;
   logic [2:0] runInc;
   logic       wrapEvent;
   logic       errEvent;
   logic [1:0] errNew;

   // Classify the current sample against the previously seen value
   always_comb begin
      legalSample = (Count <= MOD5_MAX);
      isSuccessor = prevValid_q && legalSample && (Count == mod5_next(prev_q));
      runInc      = goodRun_q + 3'd1;
   end

   // Sequence checker and lock FSM; only enabled samples move anything
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      prevValid_d = prevValid_q;
      goodRun_d   = goodRun_q;
      wrapEvent   = 1'b0;
      errEvent    = 1'b0;
      errNew      = ERR_NONE;

      if (Enable) begin
         if (legalSample) begin
            prev_d      = Count;
            prevValid_d = 1'b1;
         end else begin
            prevValid_d = 1'b0;
         end

         case (state_q)
            // FAULT holds a zero run length, so its next sample behaves
            // exactly like a fresh SEARCH sample
            SEARCH, FAULT: begin
               state_d = SEARCH;
               if (!legalSample) begin
                  errEvent  = 1'b1;
                  errNew    = ERR_ILLEGAL;
                  goodRun_d = 3'd0;
               end else if (isSuccessor) begin
                  if (runInc == LockTarget) begin
                     state_d   = LOCKED;
                     goodRun_d = 3'd0;
                  end else begin
                     goodRun_d = runInc;
                  end
               end else begin
                  goodRun_d = 3'd0;
               end
            end

            LOCKED: begin
               if (isSuccessor) begin
                  wrapEvent = (prev_q == MOD5_MAX) && (Count == 3'd0);
               end else begin
                  state_d   = FAULT;
                  goodRun_d = 3'd0;
                  errEvent  = 1'b1;
                  errNew    = legalSample ? ERR_TRANS : ERR_ILLEGAL;
               end
            end

            default: begin
               state_d   = SEARCH;
               goodRun_d = 3'd0;
            end
         endcase
      end
   end

   // FSM and sample-history registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= SEARCH;
         prev_q      <= 3'd0;
         prevValid_q <= 1'b0;
         goodRun_q   <= 3'd0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         prevValid_q <= prevValid_d;
         goodRun_q   <= goodRun_d;
      end
   end

   // Registered wrap pulse, high for one cycle after each locked wrap
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wrapPulse_q <= 1'b0;
      end else begin
         wrapPulse_q <= wrapEvent;
      end
   end

   // Error reporting: a new error outranks a simultaneous Clear
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         errorSticky_q <= 1'b0;
         errCode_q     <= ERR_NONE;
      end else if (errEvent) begin
         errorSticky_q <= 1'b1;
         errCode_q     <= errNew;
      end else if (Clear) begin
         errorSticky_q <= 1'b0;
         errCode_q     <= ERR_NONE;
      end
   end

   sat_counter #(
      .W (WRAP_W)
   ) u_wrapCounter (
      .Clock   (Clock),
      .Reset   (Reset),
      .inc_i   (wrapEvent),
      .clr_i   (Clear),
      .count_o (WrapCount)
   );

   assign WrapPulse   = wrapPulse_q;
   assign Locked      = (state_q == LOCKED);
   assign ErrorSticky = errorSticky_q;
   assign ErrCode     = errCode_q;

endmodule

// File: tb/tb_mod5_sequence_monitor.sv
// Testbench for mod5_sequence_monitor: directed scenarios with literal
// expectations followed by biased random stimulus, all compared every
// cycle against a two-mode (searching/locked) behavioural model.
module tb_mod5_sequence_monitor;

   localparam int WRAP_W   = 2;
   localparam int LOCK_CNT = 4;
   localparam int WRAP_MAX = (1 << WRAP_W) - 1;

   logic              Clock;
   logic              Reset;
   logic              Enable;
   logic [2:0]        Count;
   logic              Clear;
   logic              WrapPulse;
   logic [WRAP_W-1:0] WrapCount;
   logic              Locked;
   logic              ErrorSticky;
   logic [1:0]        ErrCode;

   int vectors    = 0;
   int miscompares = 0;
   bit checkEn    = 0;

   // Model state
   int mLast;
   int mRun;
   int mLocked;
   int mWraps;
   int mSticky;
   int mCode;
   int mPulse;
   int mWrapNow;
   int mErrNow;
   int cIn;

   mod5_sequence_monitor #(
      .WRAP_W   (WRAP_W),
      .LOCK_CNT (LOCK_CNT)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Enable      (Enable),
      .Count       (Count),
      .Clear       (Clear),
      .WrapPulse   (WrapPulse),
      .WrapCount   (WrapCount),
      .Locked      (Locked),
      .ErrorSticky (ErrorSticky),
      .ErrCode     (ErrCode)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one sample, let the DUT register it, return just after the edge
   task automatic applyStimulus(input bit en, input int c, input bit clr);
      Enable = en;
      Count  = 3'(c);
      Clear  = clr;
      @(posedge Clock);
      #1;
   endtask

   // Behavioural model: "locked" or not; a run of successor transitions
   // long enough locks it, any break while locked drops it with an error
   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         mLast = -1; mRun = 0; mLocked = 0; mWraps = 0;
         mSticky = 0; mCode = 0; mPulse = 0;
      end else begin
         mWrapNow = 0;
         mErrNow  = 0;
         if (Enable) begin
            cIn = int'(Count);
            if (mLocked != 0) begin
               if (cIn <= 4 && mLast >= 0 && cIn == (mLast + 1) % 5) begin
                  if (mLast == 4) mWrapNow = 1;
               end else begin
                  mLocked = 0;
                  mRun    = 0;
                  mErrNow = (cIn <= 4) ? 2 : 1;
               end
            end else begin
               if (cIn > 4) begin
                  mErrNow = 1;
                  mRun    = 0;
               end else if (mLast >= 0 && cIn == (mLast + 1) % 5) begin
                  mRun++;
                  if (mRun == LOCK_CNT) begin
                     mLocked = 1;
                     mRun    = 0;
                  end
               end else begin
                  mRun = 0;
               end
            end
            mLast = (cIn <= 4) ? cIn : -1;
         end
         mPulse = mWrapNow;
         if (Clear) mWraps = mWrapNow;
         else if (mWrapNow != 0 && mWraps < WRAP_MAX) mWraps++;
         if (mErrNow != 0) begin
            mSticky = 1;
            mCode   = mErrNow;
         end else if (Clear) begin
            mSticky = 0;
            mCode   = 0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge Clock) begin
      if (checkEn && !Reset) begin
         checkOutput("WrapPulse", int'(WrapPulse), mPulse);
         checkOutput("WrapCount", int'(WrapCount), mWraps);
         checkOutput("Locked", int'(Locked), mLocked);
         checkOutput("ErrorSticky", int'(ErrorSticky), mSticky);
         checkOutput("ErrCode", int'(ErrCode), mCode);
      end
   end

   initial begin
      int drv;
      int r;
      int c;
      int pulses;

      Reset  = 1'b1;
      Enable = 1'b0;
      Count  = 3'd0;
      Clear  = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b0;
      checkEn = 1;

      checkOutput("reset Locked", int'(Locked), 0);
      checkOutput("reset WrapCount", int'(WrapCount), 0);
      checkOutput("reset ErrorSticky", int'(ErrorSticky), 0);
      checkOutput("reset ErrCode", int'(ErrCode), 0);
      checkOutput("reset WrapPulse", int'(WrapPulse), 0);

      // Basic lock and first wrap
      applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 2, 0);
      applyStimulus(1, 3, 0);
      checkOutput("pre-lock Locked", int'(Locked), 0);
      applyStimulus(1, 4, 0);
      checkOutput("lock Locked", int'(Locked), 1);
      applyStimulus(1, 0, 0);
      checkOutput("first wrap WrapPulse", int'(WrapPulse), 1);
      checkOutput("first wrap WrapCount", int'(WrapCount), 1);
      applyStimulus(1, 1, 0);
      checkOutput("post wrap WrapPulse", int'(WrapPulse), 0);
      checkOutput("post wrap ErrorSticky", int'(ErrorSticky), 0);

      // Repeated value while locked
      applyStimulus(1, 2, 0);
      applyStimulus(1, 2, 0);
      checkOutput("repeat Locked", int'(Locked), 0);
      checkOutput("repeat ErrorSticky", int'(ErrorSticky), 1);
      checkOutput("repeat ErrCode", int'(ErrCode), 2);
      checkOutput("repeat WrapCount", int'(WrapCount), 1);
      applyStimulus(1, 3, 0);
      applyStimulus(0, 0, 1);
      checkOutput("clear ErrorSticky", int'(ErrorSticky), 0);
      checkOutput("clear WrapCount", int'(WrapCount), 0);

      // Illegal value in search, then relock
      applyStimulus(1, 6, 0);
      checkOutput("illegal ErrorSticky", int'(ErrorSticky), 1);
      checkOutput("illegal ErrCode", int'(ErrCode), 1);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 2, 0);
      applyStimulus(1, 3, 0);
      checkOutput("relock pending Locked", int'(Locked), 0);
      applyStimulus(1, 4, 0);
      checkOutput("relock Locked", int'(Locked), 1);

      // Enable gap inside the locked sequence
      applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 2, 0);
      applyStimulus(1, 3, 0);
      applyStimulus(0, 1, 0);
      checkOutput("gap Locked", int'(Locked), 1);
      checkOutput("gap WrapPulse", int'(WrapPulse), 0);
      checkOutput("gap ErrCode", int'(ErrCode), 1);
      applyStimulus(1, 4, 0);
      applyStimulus(1, 0, 0);
      checkOutput("gap wrap WrapPulse", int'(WrapPulse), 1);
      checkOutput("gap wrap WrapCount", int'(WrapCount), 2);

      // Saturation, then Clear coinciding with a wrap
      pulses = 0;
      for (int w = 0; w < 4; w++) begin
         applyStimulus(1, 1, 0);
         applyStimulus(1, 2, 0);
         applyStimulus(1, 3, 0);
         applyStimulus(1, 4, 0);
         applyStimulus(1, 0, (w == 3));
         if (WrapPulse) pulses++;
      end
      checkOutput("sat pulses", pulses, 4);
      checkOutput("clear+wrap WrapCount", int'(WrapCount), 1);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 2, 0);
      applyStimulus(1, 3, 0);
      applyStimulus(1, 4, 0);
      applyStimulus(1, 0, 0);
      checkOutput("pre-reset WrapCount", int'(WrapCount), 2);
      checkOutput("pre-reset Locked", int'(Locked), 1);

      // Asynchronous reset mid-cycle
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("async Locked", int'(Locked), 0);
      checkOutput("async WrapCount", int'(WrapCount), 0);
      checkOutput("async ErrorSticky", int'(ErrorSticky), 0);
      #2;
      Reset = 1'b0;
      @(posedge Clock);
      #1;
      applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 2, 0);
      applyStimulus(1, 3, 0);
      checkOutput("post-reset pending Locked", int'(Locked), 0);
      applyStimulus(1, 4, 0);
      checkOutput("post-reset Locked", int'(Locked), 1);

      // Biased random stimulus against the model
      drv = 4;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 84) c = (drv + 1) % 5;
         else if (r < 90) c = drv;
         else c = int'($urandom_range(0, 7));
         if (c <= 4) drv = c;
         applyStimulus(($urandom_range(0, 9) != 0), c, ($urandom_range(0, 39) == 0));
      end

      checkEn = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
